// File: rtl/leaf_prefetch_scheduler.sv
// Burst prefetch scheduler for the leaf FIFOs of a merger tree: round-robin
// arbitration over leaves with enough free space, credit tracking, and pass completion.
module leaf_prefetch_scheduler #(
  parameter int NUM_LEAVES = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  localparam int LEAF_W = $clog2(NUM_LEAVES),
  localparam int CRED_W = $clog2(FIFO_DEPTH) + 1,
  localparam int BLEN_W = $clog2(BURST) + 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [NUM_LEAVES*ADDR_WIDTH-1:0] i_run_base,
  input  logic [NUM_LEAVES*LEN_WIDTH-1:0]  i_run_len,
  input  logic [NUM_LEAVES-1:0]            i_fifo_read,
  output logic                             o_req_valid,
  input  logic                             i_req_ready,
  output logic [ADDR_WIDTH-1:0]            o_req_addr,
  output logic [LEAF_W-1:0]                o_req_leaf,
  output logic [BLEN_W-1:0]                o_req_len,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr   [NUM_LEAVES];
  logic [LEN_WIDTH-1:0]  remain [NUM_LEAVES];
  logic [CRED_W-1:0]     credit [NUM_LEAVES];
  logic [LEAF_W-1:0]     rr;

  logic [BLEN_W-1:0]     blen [NUM_LEAVES];
  logic [NUM_LEAVES-1:0] eligible;
  logic [NUM_LEAVES-1:0] remain_nz;
  logic [NUM_LEAVES-1:0] credit_full;
  logic [NUM_LEAVES-1:0] reserve;
  logic [LEAF_W-1:0]     cand;
  logic [LEAF_W-1:0]     win_idx;
  logic                  win_found;
  logic                  pending;
  logic                  can_load;
  logic                  active;

  assign pending  = o_req_valid && !i_req_ready;
  assign can_load = (state == S_RUN) && (!o_req_valid || i_req_ready) && win_found;
  assign active   = (state == S_RUN) || (state == S_DRAIN);
  assign o_busy   = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
  assign o_done   = (state == S_DONE);

  always_comb begin
    for (int k = 0; k < NUM_LEAVES; k++) begin
      if (remain[k] < LEN_WIDTH'(BURST)) begin
        blen[k] = remain[k][BLEN_W-1:0];
      end else begin
        blen[k] = BLEN_W'(BURST);
      end
      remain_nz[k]   = (remain[k] != '0);
      credit_full[k] = (credit[k] == CRED_W'(FIFO_DEPTH));
      eligible[k]    = remain_nz[k] && (credit[k] >= CRED_W'(blen[k]));
    end
  end

  // First eligible leaf at or above the round-robin pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      cand = rr + LEAF_W'(i);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_LEAVES; k++) begin
      reserve[k] = can_load && (win_idx == LEAF_W'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (i_start) state_next = S_LOAD;
      S_LOAD:  state_next = S_RUN;
      S_RUN:   if (!(|remain_nz) && !pending) state_next = S_DRAIN;
      S_DRAIN: if (&credit_full) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Reserve space at issue time; dequeue strobes return it, saturating at full depth.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        addr[k]   <= '0;
        remain[k] <= '0;
        credit[k] <= '0;
      end
      rr      <= '0;
      o_error <= 1'b0;
    end else if (state == S_LOAD) begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        addr[k]   <= i_run_base[k*ADDR_WIDTH +: ADDR_WIDTH];
        remain[k] <= i_run_len[k*LEN_WIDTH +: LEN_WIDTH];
        credit[k] <= CRED_W'(FIFO_DEPTH);
      end
      rr <= '0;
    end else if (active) begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        if (reserve[k]) begin
          addr[k]   <= addr[k] + ADDR_WIDTH'(blen[k]);
          remain[k] <= remain[k] - LEN_WIDTH'(blen[k]);
          credit[k] <= credit[k] - CRED_W'(blen[k]) + CRED_W'(i_fifo_read[k]);
        end else if (i_fifo_read[k]) begin
          if (credit_full[k]) begin
            o_error <= 1'b1;
          end else begin
            credit[k] <= credit[k] + CRED_W'(1);
          end
        end
      end
      if (can_load) begin
        rr <= win_idx + LEAF_W'(1);
      end
    end
  end

  // Request register holds its fields stable until the memory port accepts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_req_valid <= 1'b0;
      o_req_addr  <= '0;
      o_req_leaf  <= '0;
      o_req_len   <= '0;
    end else if (can_load) begin
      o_req_valid <= 1'b1;
      o_req_addr  <= addr[win_idx];
      o_req_leaf  <= win_idx;
      o_req_len   <= blen[win_idx];
    end else if (o_req_valid && i_req_ready) begin
      o_req_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leaf_prefetch_scheduler.sv
// Directed self-checking bench for leaf_prefetch_scheduler with hand-computed
// request sequences, credit gating, backpressure and reset scenarios.
module tb_leaf_prefetch_scheduler;

  localparam int NL = 4;
  localparam int AW = 32;
  localparam int LW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NL*AW-1:0] run_base;
  logic [NL*LW-1:0] run_len;
  logic [NL-1:0]   fifo_read;
  logic            req_ready;
  logic            o_req_valid;
  logic [AW-1:0]   o_req_addr;
  logic [1:0]      o_req_leaf;
  logic [2:0]      o_req_len;
  logic            o_busy;
  logic            o_done;
  logic            o_error;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int done_base = 0;
  logic [36:0] q[$];

  leaf_prefetch_scheduler #(
    .NUM_LEAVES(NL), .FIFO_DEPTH(16), .BURST(4), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_run_base(run_base),
    .i_run_len(run_len),
    .i_fifo_read(fifo_read),
    .o_req_valid(o_req_valid),
    .i_req_ready(req_ready),
    .o_req_addr(o_req_addr),
    .o_req_leaf(o_req_leaf),
    .o_req_len(o_req_len),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_error(o_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Records a handshake that the coming edge will complete, then advances.
  task automatic step();
    if (o_req_valid && req_ready) q.push_back({o_req_addr, o_req_leaf, o_req_len});
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic [31:0] b0, b1, b2, b3, l0, l1, l2, l3);
    run_base  = {b3, b2, b1, b0};
    run_len   = {l3, l2, l1, l0};
    done_base = done_cnt;
    q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expectReq(input string tag, input int idx, input logic [31:0] a,
                           input logic [1:0] lf, input logic [2:0] ln);
    logic [36:0] got;
    got = (idx < q.size()) ? q[idx] : '1;
    checkOutput(tag, {27'd0, got}, {27'd0, a, lf, ln});
  endtask

  task automatic readLeaf(input logic [NL-1:0] mask, input int n);
    fifo_read = mask;
    steps(n);
    fifo_read = '0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [36:0] capture;
    int changes;

    rst = 1'b1; start = 1'b0; run_base = '0; run_len = '0;
    fifo_read = '0; req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", o_req_valid, 0);
    checkOutput("rst_addr", o_req_addr, 0);
    checkOutput("rst_leaf", o_req_leaf, 0);
    checkOutput("rst_len", o_req_len, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_error", o_error, 0);
    rst = 1'b0;
    step();

    // Single leaf with a short tail burst.
    readLeaf(4'b1000, 1);
    checkOutput("idle_read_no_err", o_error, 0);
    req_ready = 1'b1;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h100, 0, 0, 0, 10);
    steps(2);
    checkOutput("first_req_valid", o_req_valid, 1);
    steps(10);
    checkOutput("single_count", q.size(), 3);
    expectReq("single_r0", 0, 32'h100, 2'd3, 3'd4);
    expectReq("single_r1", 1, 32'h104, 2'd3, 3'd4);
    expectReq("single_r2", 2, 32'h108, 2'd3, 3'd2);
    checkOutput("single_busy_drain", o_busy, 1);
    checkOutput("single_no_done_yet", done_cnt - done_base, 0);
    readLeaf(4'b1000, 10);
    steps(5);
    checkOutput("single_done_once", done_cnt - done_base, 1);
    checkOutput("single_idle_busy", o_busy, 0);

    // Round-robin across four equal runs.
    applyStimulus(32'h0, 32'h1000, 32'h2000, 32'h3000, 8, 8, 8, 8);
    steps(14);
    checkOutput("rr_count", q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      expectReq($sformatf("rr_r%0d", i), i, 32'h1000 * (i % 4) + 32'd4 * (i / 4),
                2'(i % 4), 3'd4);
    end
    readLeaf(4'b1111, 8);
    steps(5);
    checkOutput("rr_done_once", done_cnt - done_base, 1);

    // Backpressure holds the first request stable.
    req_ready = 1'b0;
    applyStimulus(32'h500, 32'h0, 32'h0, 32'h0, 8, 0, 0, 0);
    steps(2);
    checkOutput("bp_valid", o_req_valid, 1);
    capture = {o_req_addr, o_req_leaf, o_req_len};
    changes = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!o_req_valid || {o_req_addr, o_req_leaf, o_req_len} != capture) changes++;
    end
    checkOutput("bp_stable", changes, 0);
    checkOutput("bp_first", {27'd0, capture}, {27'd0, 32'h500, 2'd0, 3'd4});
    req_ready = 1'b1;
    step();
    checkOutput("bp_second", {27'd0, o_req_valid, o_req_addr, o_req_leaf, o_req_len},
                {27'd0, 1'b1, 32'h504, 2'd0, 3'd4});
    steps(3);
    checkOutput("bp_count", q.size(), 2);
    readLeaf(4'b0001, 8);
    steps(5);
    checkOutput("bp_done_once", done_cnt - done_base, 1);

    // Credit gating, simultaneous reserve/return, overflow.
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 40, 0, 0, 0);
    steps(10);
    checkOutput("gate_count4", q.size(), 4);
    checkOutput("gate_valid_low", o_req_valid, 0);
    readLeaf(4'b0001, 1);
    steps(3);
    checkOutput("gate_credit1", q.size(), 4);
    readLeaf(4'b0001, 4);
    step();
    checkOutput("gate_credit4", q.size(), 5);
    expectReq("gate_r4", 4, 32'h10, 2'd0, 3'd4);
    readLeaf(4'b0001, 2);
    steps(3);
    checkOutput("sim_credit3", q.size(), 5);
    readLeaf(4'b0001, 1);
    steps(3);
    checkOutput("sim_credit4", q.size(), 6);
    expectReq("sim_r5", 5, 32'h14, 2'd0, 3'd4);
    checkOutput("pre_ovf_error", o_error, 0);
    readLeaf(4'b0010, 1);
    checkOutput("ovf_error", o_error, 1);
    readLeaf(4'b0001, 32);
    steps(10);
    checkOutput("gate_total", q.size(), 10);
    expectReq("gate_r9", 9, 32'h24, 2'd0, 3'd4);
    checkOutput("ovf_sat_done", done_cnt - done_base, 1);
    checkOutput("error_sticky", o_error, 1);

    // Empty table: LOAD, RUN, DRAIN then DONE.
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    checkOutput("zero_load_busy", o_busy, 1);
    step();
    checkOutput("zero_run_busy", o_busy, 1);
    step();
    checkOutput("zero_drain_busy", {o_busy, o_done}, 2'b10);
    step();
    checkOutput("zero_done", {o_busy, o_done}, 2'b01);
    step();
    checkOutput("zero_after", {o_busy, o_done}, 2'b00);
    checkOutput("zero_done_once", done_cnt - done_base, 1);

    // Asynchronous reset with a request outstanding, then a fresh pass.
    req_ready = 1'b0;
    applyStimulus(32'h800, 32'h900, 32'ha00, 32'hb00, 8, 8, 8, 8);
    steps(2);
    checkOutput("mid_valid", o_req_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_outputs", {o_req_valid, o_req_addr, o_req_leaf, o_req_len,
                                 o_busy, o_done, o_error}, 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    req_ready = 1'b1;
    applyStimulus(32'h0, 32'h700, 32'h0, 32'h0, 0, 4, 0, 0);
    steps(4);
    checkOutput("restart_count", q.size(), 1);
    expectReq("restart_r0", 0, 32'h700, 2'd1, 3'd4);
    readLeaf(4'b0010, 4);
    steps(5);
    checkOutput("restart_done", done_cnt - done_base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
